// File: rtl/game_pkg.sv
// Shared playfield geometry and line-clear sequencer state encodings.
package game_pkg;

    localparam int GAME_ROWS = 20;
    localparam int GAME_COLS = 12;
    localparam int ADDR_W    = 5;

    localparam logic [GAME_COLS-1:0] FULL_ROW = '1;
    localparam logic [2:0]           CNT_MAX  = 3'd7;

    typedef enum logic [2:0] {
        CLR_IDLE,
        CLR_SCAN_RD,
        CLR_SCAN_CHK,
        CLR_SH_RD,
        CLR_SH_WR,
        CLR_TOP_CLR,
        CLR_DONE
    } clr_state_e;

endpackage

// File: rtl/line_clear_seq.sv
// Line-clear sequencer: scans the playfield bottom-up and collapses full rows.
// state    | meaning
// IDLE     | waiting for clr_start
// SCAN_RD  | read row r
// SCAN_CHK | test row r for full
// SH_RD    | read row k-1
// SH_WR    | write that row into row k
// TOP_CLR  | zero row 0, count the line, rescan r
// DONE     | pulse done, drop busy
module line_clear_seq
    import game_pkg::*;
#(
    parameter int ROWS = GAME_ROWS,
    parameter int COLS = GAME_COLS
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              clr_start_i,
    input  logic              gnt_i,
    input  logic [COLS-1:0]   rdata_i,
    output logic              req_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [COLS-1:0]   wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [2:0]        count_o
);

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
    localparam logic [COLS-1:0]   ALL_ONES = '1;

    clr_state_e        state_q;
    logic [ADDR_W-1:0] r_q, k_q;
    logic [2:0]        cnt_q;
    logic              busy_q, done_q, stall_q;
    logic [COLS-1:0]   hold_q, wr_data;

    // A stalled shift write must not pick up the display's read data.
    assign wr_data = stall_q ? hold_q : rdata_i;

    always_comb begin
        req_o   = 1'b0;
        we_o    = 1'b0;
        addr_o  = '0;
        wdata_o = '0;
        case (state_q)
            CLR_SCAN_RD: begin req_o = 1'b1; addr_o = r_q; end
            CLR_SH_RD:   begin req_o = 1'b1; addr_o = k_q - 5'd1; end
            CLR_SH_WR:   begin req_o = 1'b1; we_o = 1'b1; addr_o = k_q; wdata_o = wr_data; end
            CLR_TOP_CLR: begin req_o = 1'b1; we_o = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state_q <= CLR_IDLE;
            r_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            stall_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            done_q  <= 1'b0;
            stall_q <= (state_q == CLR_SH_WR) && !gnt_i;
            case (state_q)
                CLR_IDLE: if (clr_start_i) begin
                    r_q     <= LAST_ROW;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= CLR_SCAN_RD;
                end
                CLR_SCAN_RD: if (gnt_i) state_q <= CLR_SCAN_CHK;
                CLR_SCAN_CHK: begin
                    if (rdata_i == ALL_ONES) begin
                        k_q     <= r_q;
                        state_q <= (r_q == '0) ? CLR_TOP_CLR : CLR_SH_RD;
                    end else if (r_q == '0) begin
                        state_q <= CLR_DONE;
                    end else begin
                        r_q     <= r_q - 5'd1;
                        state_q <= CLR_SCAN_RD;
                    end
                end
                CLR_SH_RD: if (gnt_i) state_q <= CLR_SH_WR;
                CLR_SH_WR: begin
                    hold_q <= wr_data;
                    if (gnt_i) begin
                        k_q     <= k_q - 5'd1;
                        state_q <= (k_q == 5'd1) ? CLR_TOP_CLR : CLR_SH_RD;
                    end
                end
                CLR_TOP_CLR: if (gnt_i) begin
                    if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 3'd1;
                    state_q <= CLR_SCAN_RD;
                end
                CLR_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= CLR_IDLE;
                end
                default: state_q <= CLR_IDLE;
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/game_area_arbiter.sv
// Shares the single-port playfield RAM between the display fetch, the
// line-clear sequencer and game logic (priority in that order).
module game_area_arbiter
    import game_pkg::*;
#(
    parameter int ROWS = GAME_ROWS,
    parameter int COLS = GAME_COLS
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [COLS-1:0]   disp_data,
    input  logic              logic_req,
    input  logic              logic_we,
    input  logic [ADDR_W-1:0] logic_addr,
    input  logic [COLS-1:0]   logic_wdata,
    output logic              logic_ack,
    output logic [COLS-1:0]   logic_rdata,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [2:0]        clr_count,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [COLS-1:0]   ram_wdata,
    input  logic [COLS-1:0]   ram_rdata
);

    logic              disp_ok, logic_ok, seq_req, seq_we, seq_gnt, logic_gnt;
    logic [ADDR_W-1:0] seq_addr;
    logic [COLS-1:0]   seq_wdata;
    logic              disp_pend_q, disp_ok_q, lack_q, lrd_pend_q, lok_q;
    logic [COLS-1:0]   disp_q, disp_d, lrd_q, lrd_d;

    assign disp_ok   = 32'(disp_addr) < ROWS;
    assign logic_ok  = 32'(logic_addr) < ROWS;
    assign seq_gnt   = seq_req && !disp_req && !rst;
    // lack_q blocks a regrant while the requester still holds req in its ack cycle.
    assign logic_gnt = logic_req && !lack_q && !clr_busy && !seq_req && !disp_req && !rst;

    line_clear_seq #(.ROWS(ROWS), .COLS(COLS)) u_seq (
        .vga_clk     (vga_clk),
        .rst         (rst),
        .clr_start_i (clr_start),
        .gnt_i       (seq_gnt),
        .rdata_i     (ram_rdata),
        .req_o       (seq_req),
        .we_o        (seq_we),
        .addr_o      (seq_addr),
        .wdata_o     (seq_wdata),
        .busy_o      (clr_busy),
        .done_o      (clr_done),
        .count_o     (clr_count)
    );

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (!rst) begin
            if (disp_req) begin
                if (disp_ok) ram_addr = disp_addr;
            end else if (seq_req) begin
                ram_addr  = seq_addr;
                ram_we    = seq_we;
                ram_wdata = seq_wdata;
            end else if (logic_gnt && logic_ok) begin
                ram_addr  = logic_addr;
                ram_we    = logic_we;
                ram_wdata = logic_wdata;
            end
        end
    end

    // Read data is passed through in the cycle it arrives, then held.
    assign disp_d      = disp_pend_q ? (disp_ok_q ? ram_rdata : '0) : disp_q;
    assign lrd_d       = lrd_pend_q ? (lok_q ? ram_rdata : '0) : lrd_q;
    assign disp_data   = disp_d;
    assign logic_rdata = lrd_d;
    assign logic_ack   = lack_q;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            disp_pend_q <= 1'b0;
            disp_ok_q   <= 1'b0;
            disp_q      <= '0;
            lack_q      <= 1'b0;
            lrd_pend_q  <= 1'b0;
            lok_q       <= 1'b0;
            lrd_q       <= '0;
        end else begin
            disp_pend_q <= disp_req;
            disp_ok_q   <= disp_ok;
            disp_q      <= disp_d;
            lack_q      <= logic_gnt;
            lrd_pend_q  <= logic_gnt && !logic_we;
            lok_q       <= logic_ok;
            lrd_q       <= lrd_d;
        end
    end

endmodule

// File: doc/game_area_arbiter.md
GAME_AREA_ARBITER -- requirements
Module: game_area_arbiter

Interface
REQ-001 SHALL have parameter ROWS, default 20, meaning number of playfield rows.
REQ-002 SHALL have parameter COLS, default 12, meaning playfield row width in bits.
REQ-003 SHALL have port vga_clk, input, 1, meaning the clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port disp_req, input, 1, meaning one-cycle strobe from the drawer to fetch a new row.
REQ-006 SHALL have port disp_addr, input, 5, meaning the row to fetch for display.
REQ-007 SHALL have port disp_data, output, COLS, meaning the held display row.
REQ-008 SHALL have ports logic_req (input, 1), logic_we (input, 1), logic_addr (input, 5) and logic_wdata (input, COLS), meaning the game-logic access request.
REQ-009 SHALL have ports logic_ack (output, 1) and logic_rdata (output, COLS), meaning game-logic completion and read data.
REQ-010 SHALL have ports clr_start (input, 1), clr_busy (output, 1), clr_done (output, 1) and clr_count (output, 3), meaning the line-clear sequencer control.
REQ-011 SHALL have ports ram_addr (output, 5), ram_we (output, 1), ram_wdata (output, COLS) and ram_rdata (input, COLS), meaning the single-port RAM with 1-cycle synchronous read.

Function
REQ-012 SHALL grant the RAM port to at most one requester per cycle, with priority display > clear sequencer > game logic.
REQ-013 SHALL, on a disp_req grant, drive ram_addr=disp_addr with ram_we=0, and load disp_data from ram_rdata on the next cycle; disp_data SHALL hold until the next fetch.
REQ-014 SHALL treat logic_req as level-held until logic_ack, which SHALL be a 1-cycle pulse asserted the cycle after the grant.
REQ-015 SHALL, for a logic read, make logic_rdata valid in the same cycle as logic_ack; a logic write SHALL complete at grant.
REQ-016 SHALL not grant logic_req while clr_busy=1; the request stays pending and is not lost.
REQ-017 SHALL, when a grant is lost to display, stall the clear sequencer or logic access for that cycle and retry unchanged.
REQ-018 SHALL implement the clear FSM states IDLE, SCAN_RD, SCAN_CHK, SH_RD, SH_WR, TOP_CLR and DONE.
REQ-019 SHALL, on clr_start in IDLE, set r=ROWS-1, clr_count=0 and clr_busy=1, and go to SCAN_RD; clr_start outside IDLE SHALL be ignored.
REQ-020 SHALL, in SCAN_RD, read row r, then in SCAN_CHK test it: if row == all-ones, set k=r and go to SH_RD; otherwise, if r==0 go to DONE, else decrement r and go to SCAN_RD.
REQ-021 SHALL, in SH_RD, read row k-1, and in SH_WR write that data to row k; then decrement k, and if k==0 go to TOP_CLR, else go to SH_RD.
REQ-022 SHALL, in TOP_CLR, write 0 to row 0, increment clr_count (saturating at 7), and rescan the same r via SCAN_RD without decrementing.
REQ-023 SHALL, in DONE, pulse clr_done for 1 cycle, drop clr_busy, and return to IDLE; clr_count SHALL hold until the next clr_start.
REQ-024 SHALL, when r==0 is full, skip the shift and go directly to TOP_CLR.
REQ-025 SHALL drive ram_we low in every cycle without a write grant.
REQ-026 SHALL ignore a disp_addr or logic_addr >= ROWS: no RAM access, the read returns 0, and logic is still acked.

Reset
REQ-027 SHALL, on rst, set disp_data=0, logic_ack=0, logic_rdata=0, clr_busy=0, clr_done=0, clr_count=0, ram_we=0, ram_addr=0, ram_wdata=0 and FSM=IDLE.
REQ-028 SHALL, on rst mid-clear, abort immediately; RAM contents are not restored.

Structure
REQ-029 SHALL take ROWS, COLS, FULL_ROW and the clear-FSM state encodings from the shared game_pkg.
REQ-030 SHALL place the clear FSM in sub-module line_clear_seq; the arbiter mux stays in the top level.

Verification
REQ-031 SHALL cover: rows 19 and 18 = 0xFFF, row 17 = 0x001, clr_start -> clr_done once, clr_count=2, row 19 = 0x001, rows 0-1 = 0.
REQ-032 SHALL cover: disp_req on every 3rd cycle during a clear -> final RAM identical to the undisturbed run, and disp_data correct 1 cycle after each strobe.
REQ-033 SHALL cover: logic write row 5 = 0x0A5, then read row 5 -> logic_rdata=0x0A5 with logic_ack one cycle after grant.
REQ-034 SHALL cover: logic_req held during clr_busy -> no ack until after clr_done, then one ack.
REQ-035 SHALL cover: only row 0 = 0xFFF, clear -> row 0 = 0, clr_count=1, no SH_RD visits.
REQ-036 SHALL cover: rst asserted in SH_WR -> next cycle clr_busy=0, ram_we=0 and FSM=IDLE.
